// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg: state encodings, parity modes and parity helper shared by UART Rx/Tx
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE    = 0;
    localparam int PARITY_EVEN    = 1;
    localparam int PARITY_ODD     = 2;
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Expected parity bit; callers zero-extend narrower words to MAX_DATA_WIDTH.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// uart_sync: flip-flop synchronizer chain, resets to the idle-high line level
// Rev 1.0
// ============================================================================
module uart_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param: parametrised UART receiver with ready/valid word output
// Rev 1.0
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 1,
    parameter int SYNC_STAGES    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    input  logic                  data_ready,
    output logic                  rx_error,
    output logic                  overrun,
    output logic                  rx_busy
);

    localparam int TICK_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] c_half_last = TICK_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] c_full_last = TICK_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_data_last = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  c_stop_last = BIT_W'(STOP_BITS - 1);

    logic                        w_line;
    logic                        w_stop_framing;
    logic [MAX_DATA_WIDTH-1:0]   w_par_data;

    rx_state_t                   r_state;
    logic [TICK_W-1:0]           r_tick;
    logic [BIT_W-1:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0]       r_shift;
    logic                        r_par_err;
    logic                        r_frm_err;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (serial_in),
        .sync_out (w_line)
    );

    always_comb begin
        w_par_data                 = '0;
        w_par_data[DATA_WIDTH-1:0] = r_shift;
    end

    // Framing state including the stop sample being taken this cycle.
    assign w_stop_framing = r_frm_err | ~w_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tick        <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_err     <= 1'b0;
            r_frm_err     <= 1'b0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            overrun       <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (data_is_valid && data_ready) begin
                data_is_valid <= 1'b0;
                rx_error      <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_line) begin
                        r_state <= ST_START;
                        r_tick  <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_tick == c_half_last) begin
                        r_tick <= '0;
                        if (w_line) begin
                            r_state <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_tick == c_full_last) begin
                        r_tick  <= '0;
                        r_shift <= {w_line, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (r_tick == c_full_last) begin
                        r_tick    <= '0;
                        r_bit_cnt <= '0;
                        r_par_err <= (w_line != parity_bit(w_par_data, PARITY_MODE));
                        r_state   <= ST_STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (r_tick == c_full_last) begin
                        r_tick    <= '0;
                        r_frm_err <= w_stop_framing;
                        if (r_bit_cnt == c_stop_last) begin
                            r_bit_cnt <= '0;
                            // A held word that is not leaving this cycle wins; the new one is lost.
                            if (!data_is_valid || data_ready) begin
                                received_data <= r_shift;
                                data_is_valid <= 1'b1;
                                rx_error      <= r_par_err | w_stop_framing;
                            end else begin
                                overrun <= 1'b1;
                            end
                            if (w_stop_framing) begin
                                r_state <= ST_WAIT_IDLE;
                            end else begin
                                r_state <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (w_line) begin
                        r_state <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tick  <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation Rx path for the UART block, generalised in data width, oversampling ratio, parity mode and stop-bit count. It adds a ready/valid output handshake, overrun detection, framing and parity error reporting, and start-bit glitch rejection. It sits between the pin-side `serial_in` and any word-level consumer: the loopback test wrapper, a FIFO, or a bus bridge.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal 5..9.
- `CLOCKS_PER_BIT`, 8: clk cycles per bit; even, ≥4.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 3: flip-flop synchronizer depth on `serial_in`, ≥2.
- `clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `serial_in` in 1: asynchronous line input; idle high.
- `received_data` out DATA_WIDTH: received word, LSB first on the line. Stable while `data_is_valid` = 1.
- `data_is_valid` out 1: word available. Held until accepted.
- `data_ready` in 1: consumer accepts the word on a clk edge where valid & ready.
- `rx_error` out 1: qualifies the current word. Set on parity error or framing error. Valid only with `data_is_valid`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `rx_busy` out 1: high in any state other than IDLE.

## Operation
- **Reset values:**
  - synchronizer chain all 1.
  - FSM in IDLE; tick and bit counters 0.
  - `received_data` = 0.
  - `data_is_valid`, `rx_error`, `overrun`, `rx_busy` all 0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - **IDLE:** synced line = 0 → START, tick counter = 0.
  - **START:**
    - At tick `CLOCKS_PER_BIT/2 - 1`, sample the line.
    - Sample = 1 → glitch; return to IDLE with no flags.
    - Sample = 0 → DATA, tick counter = 0, bit counter = 0.
  - **DATA:**
    - Sample at each tick `CLOCKS_PER_BIT - 1` and shift in LSB first.
    - After `DATA_WIDTH` samples → PARITY, or → STOP if `PARITY_MODE` = 0.
  - **PARITY:**
    - Sample one bit. Expected value = XOR of data bits (even), or its inverse (odd).
    - Mismatch sets the internal parity-error flag.
  - **STOP:**
    - Sample `STOP_BITS` bits. Any stop sample = 0 sets the framing flag.
    - After the last stop sample, deliver the word, then go to IDLE.
    - If the framing flag is set, go to WAIT_IDLE instead.
  - **WAIT_IDLE:** stay until the synced line = 1, then → IDLE. This prevents a break from retriggering.
- **Delivery:**
  - If the output register is free, or is being accepted this same cycle: load `received_data`, set `data_is_valid` = 1, and set `rx_error` = parity flag | framing flag.
  - Otherwise: drop the new word, pulse `overrun`, leave the held word untouched.
- **Handshake:** an edge with `data_is_valid` & `data_ready` and no simultaneous delivery clears `data_is_valid` and `rx_error`.
- **Reset mid-frame:** immediate abort to reset values. No partial word is ever delivered.
- Tick counter width: `$clog2(CLOCKS_PER_BIT)`. Bit counter width: `$clog2(DATA_WIDTH+1)`.

## Timing
- **Synchronizer:** a `serial_in` change is visible to the FSM `SYNC_STAGES` cycles later.
- **Sample points:** the start sample is taken `CLOCKS_PER_BIT/2` cycles after the FSM sees low. Each later sample follows `CLOCKS_PER_BIT` cycles after the previous one.
- **Latency:** from the first clk edge sampling `serial_in` = 0 to `data_is_valid` = 1, L = `SYNC_STAGES` + `CLOCKS_PER_BIT/2` + (`DATA_WIDTH` + P + `STOP_BITS`) × `CLOCKS_PER_BIT`, where P = 1 if parity is enabled, else 0. Defaults: L = 87.
- **Output registers:** all outputs are registered. `overrun` is exactly 1 cycle wide.
- **Back-to-back frames:** a start bit immediately following the last stop bit is accepted. FSM re-entry into IDLE takes no extra cycle beyond the STOP sample.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encodings.
  - `PARITY_NONE` / `PARITY_EVEN` / `PARITY_ODD` constants.
  - the parity helper function.
  - These are shared with the matching parametrised transmitter.
- **Sub-module `uart_sync`:**
  - parametrised `SYNC_STAGES` flip-flop chain with async reset to 1.
  - instantiated once on `serial_in`.

## Test plan
- **Clean frame:** defaults, `data_ready` = 1, send 0xA5 with parity 0 and stop 1 → `received_data` = 0xA5, `data_is_valid` high for 1 cycle, `rx_error` = 0, latency 87 cycles.
- **Parity error:** send 0xA5 with parity bit = 1 → word 0xA5 delivered with `rx_error` = 1.
- **Framing error then break:** send 0x3C, stop bit = 0, line held low for 40 cycles → `rx_error` = 1. No second word until the line returns high and a new start bit arrives.
- **Glitch rejection:** line pulsed low for 2 cycles → no delivery, `rx_busy` returns to 0 within `SYNC_STAGES` + 4 cycles.
- **Overrun:** `data_ready` = 0, send 0x11 then 0x22 → 0x11 held, `overrun` pulses once at the end of 0x22. Then `data_ready` = 1 → 0x11 accepted, valid drops.
- **Reset mid-frame:** `DATA_WIDTH` = 7, `PARITY_MODE` = 2, `STOP_BITS` = 2. Assert `reset` during data bit 3 → all outputs return to 0 immediately. A following 0x55 frame with odd parity bit 1 → 0x55, `rx_error` = 0.
